pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry skid pipeline register with flush
// Optional stall performance counter enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int DATA_WIDTH = 80,
  parameter int CTRL_WIDTH = 43,
  parameter int DEST_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DEST_WIDTH-1:0] in_dest,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DEST_WIDTH-1:0] out_dest,
  output logic [15:0]           stall_count
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_main_data;
  logic [CTRL_WIDTH-1:0] r_main_ctrl;
  logic [DEST_WIDTH-1:0] r_main_dest;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic [CTRL_WIDTH-1:0] r_skid_ctrl;
  logic [DEST_WIDTH-1:0] r_skid_dest;
  logic                  w_accept;
  logic                  w_consume;
  logic                  w_load_main;
  logic                  w_load_skid;
  logic                  w_main_from_skid;

  // in_ready is a pure decode of the state register, never of out_ready
  assign in_ready  = (r_state != S_FULL);
  assign out_valid = (r_state != S_EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_consume = out_valid && out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = S_ONE;
          w_load_main = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && w_consume) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = S_FULL;
          w_load_skid = 1'b1;
        end else if (w_consume) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_consume) begin
          w_state_nxt      = S_ONE;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt      = S_EMPTY;
      w_load_main      = 1'b0;
      w_load_skid      = 1'b0;
      w_main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_main_dest <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_dest <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main) begin
        r_main_data <= in_data;
        r_main_ctrl <= in_ctrl;
        r_main_dest <= in_dest;
      end else if (w_main_from_skid) begin
        r_main_data <= r_skid_data;
        r_main_ctrl <= r_skid_ctrl;
        r_main_dest <= r_skid_dest;
      end
      if (w_load_skid) begin
        r_skid_data <= in_data;
        r_skid_ctrl <= in_ctrl;
        r_skid_dest <= in_dest;
      end
    end
  end

  // Control and destination are squashed when empty so a bubble never writes back
  assign out_data = r_main_data;
  assign out_ctrl = out_valid ? r_main_ctrl : '0;
  assign out_dest = out_valid ? r_main_dest : '0;

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= 16'd0;
    end else if (out_valid && !out_ready && !flush && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = 16'd0;
`endif

endmodule
